// File: rtl/uart_tx_frame_if.sv
// Host-side handshake and serial outputs of the UART transmit framer.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop; each bit PRESCALE clocks.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
//
// state    | meaning
// S_IDLE   | line high, waiting for Data_Valid
// S_START  | start bit (0)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit (only when latched PAR_EN=1)
// S_STOP   | stop bit(s) (1)
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic            CLK,
  input  logic            RST,
  uart_tx_frame_if.slave  bus
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_acc_q, par_acc_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  tick;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_acc_d = par_acc_q;
    tick      = (cnt_q == CNT_LAST);

    if (state_q != S_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.Data_Valid) begin
          state_d   = S_START;
          shift_d   = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          // Parity accumulator starts at the type bit so odd parity falls out of the XOR chain.
          par_acc_d = bus.PAR_TYP;
          cnt_d     = '0;
          bit_d     = '0;
        end
      end
      S_START: begin
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          par_acc_d = par_acc_q ^ shift_q[0];
          shift_d   = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick) begin
`ifdef UART_TX_TWO_STOP_EN
          // Bit counter is idle during STOP, so it marks which stop bit is on the line.
          if (bit_q == '0) begin
            bit_d = BW'(1);
          end else begin
            bit_d   = '0;
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_acc_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_acc_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_acc_q <= par_acc_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: default instance (PRESCALE=8) plus a PRESCALE=1 instance.
module tb_uart_tx_frame;

  localparam int DW = 8;
  localparam int P  = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
  localparam logic [15:0] STOP_MASK = 16'h0003;
`else
  localparam int NSTOP = 1;
  localparam logic [15:0] STOP_MASK = 16'h0001;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame_if #(.DATA_WIDTH(DW)) bus ();
  uart_tx_frame_if #(.DATA_WIDTH(DW)) fbus ();

  uart_tx_frame #(.DATA_WIDTH(DW), .PRESCALE(P)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  uart_tx_frame #(.DATA_WIDTH(DW), .PRESCALE(1)) u_fast (
    .CLK (CLK),
    .RST (RST),
    .bus (fbus.slave)
  );

  // Starts at a negedge with IDLE; returns at the negedge one cycle after the accepting edge.
  task automatic pulse(input logic [7:0] d, input logic pe, input logic pt);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = 1'b1;
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
  endtask

  // Records the first sample of each bit while Busy is high, plus any in-bit changes.
  task automatic capture(output logic [15:0] bits, output int len, output int glitches);
    int idx;
    bits = '0;
    len = 0;
    glitches = 0;
    while (bus.Busy === 1'b1 && len < 300) begin
      idx = len / P;
      if (idx < 16) begin
        if (len % P == 0) bits[idx] = bus.TX_OUT;
        else if (bus.TX_OUT !== bits[idx]) glitches++;
      end
      len++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    bus.P_DATA = '0; bus.Data_Valid = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    fbus.P_DATA = '0; fbus.Data_Valid = 1'b0; fbus.PAR_EN = 1'b0; fbus.PAR_TYP = 1'b0;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (bus.TX_OUT !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", bus.TX_OUT); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
    checks++; if (fbus.TX_OUT !== 1'b1) begin errors++; $display("FAIL reset_fast_tx: got %b expected 1", fbus.TX_OUT); end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (bus.Busy !== 1'b0 || bus.TX_OUT !== 1'b1) begin
      errors++; $display("FAIL reset_release_idle: got busy=%b tx=%b expected busy=0 tx=1", bus.Busy, bus.TX_OUT);
    end
  endtask

  task automatic test_parity_even();
    logic [15:0] bits; int len; int gl;
    pulse(8'hA5, 1'b1, 1'b0);
    checks++; if (bus.TX_OUT !== 1'b0 || bus.Busy !== 1'b1) begin
      errors++; $display("FAIL even_latency: got tx=%b busy=%b expected tx=0 busy=1", bus.TX_OUT, bus.Busy);
    end
    capture(bits, len, gl);
    checks++; if (bits !== (16'h014A | (STOP_MASK << 10))) begin
      errors++; $display("FAIL even_bits: got %h expected %h", bits, 16'h014A | (STOP_MASK << 10));
    end
    checks++; if (len !== P * (10 + NSTOP)) begin errors++; $display("FAIL even_len: got %0d expected %0d", len, P * (10 + NSTOP)); end
    checks++; if (gl !== 0) begin errors++; $display("FAIL even_bit_hold: got %0d in-bit changes expected 0", gl); end
    checks++; if (bus.TX_OUT !== 1'b1) begin errors++; $display("FAIL even_idle_tx: got %b expected 1", bus.TX_OUT); end
  endtask

  task automatic test_parity_odd();
    logic [15:0] bits; int len; int gl;
    pulse(8'hA5, 1'b1, 1'b1);
    capture(bits, len, gl);
    checks++; if (bits !== (16'h034A | (STOP_MASK << 10))) begin
      errors++; $display("FAIL odd_bits: got %h expected %h", bits, 16'h034A | (STOP_MASK << 10));
    end
    checks++; if (len !== P * (10 + NSTOP)) begin errors++; $display("FAIL odd_len: got %0d expected %0d", len, P * (10 + NSTOP)); end
  endtask

  task automatic test_no_parity();
    logic [15:0] bits; int len; int gl;
    pulse(8'hA5, 1'b0, 1'b0);
    capture(bits, len, gl);
    checks++; if (bits !== (16'h014A | (STOP_MASK << 9))) begin
      errors++; $display("FAIL nopar_bits: got %h expected %h", bits, 16'h014A | (STOP_MASK << 9));
    end
    checks++; if (len !== P * (9 + NSTOP)) begin errors++; $display("FAIL nopar_len: got %0d expected %0d", len, P * (9 + NSTOP)); end
  endtask

  task automatic test_interference();
    logic [15:0] bits; int len; int gl; int busy_after;
    pulse(8'h3C, 1'b1, 1'b0);
    fork
      capture(bits, len, gl);
      begin
        repeat (5) @(negedge CLK);
        bus.Data_Valid = 1'b1;
        bus.P_DATA     = 8'hFF;
        for (int i = 0; i < 40; i++) begin
          bus.PAR_TYP = ~bus.PAR_TYP;
          @(negedge CLK);
        end
        bus.Data_Valid = 1'b0;
        bus.PAR_TYP    = 1'b0;
      end
    join
    checks++; if (bits !== (16'h0078 | (STOP_MASK << 10))) begin
      errors++; $display("FAIL interf_bits: got %h expected %h", bits, 16'h0078 | (STOP_MASK << 10));
    end
    checks++; if (len !== P * (10 + NSTOP)) begin errors++; $display("FAIL interf_len: got %0d expected %0d", len, P * (10 + NSTOP)); end
    busy_after = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.Busy !== 1'b0 || bus.TX_OUT !== 1'b1) busy_after++;
      @(negedge CLK);
    end
    checks++; if (busy_after !== 0) begin errors++; $display("FAIL interf_no_resend: got %0d busy cycles expected 0", busy_after); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits; int len; int gl;
    bus.P_DATA = 8'h00; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
    @(negedge CLK);
    capture(bits, len, gl);
    checks++; if (len !== P * (9 + NSTOP)) begin errors++; $display("FAIL b2b_len1: got %0d expected %0d", len, P * (9 + NSTOP)); end
    checks++; if (bus.Busy !== 1'b0 || bus.TX_OUT !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: got busy=%b tx=%b expected busy=0 tx=1", bus.Busy, bus.TX_OUT);
    end
    @(negedge CLK);
    checks++; if (bus.Busy !== 1'b1 || bus.TX_OUT !== 1'b0) begin
      errors++; $display("FAIL b2b_gap_len: got busy=%b tx=%b expected busy=1 tx=0", bus.Busy, bus.TX_OUT);
    end
    bus.Data_Valid = 1'b0;
    capture(bits, len, gl);
    checks++; if (len !== P * (9 + NSTOP)) begin errors++; $display("FAIL b2b_len2: got %0d expected %0d", len, P * (9 + NSTOP)); end
    checks++; if (bits !== (STOP_MASK << 9)) begin errors++; $display("FAIL b2b_bits2: got %h expected %h", bits, STOP_MASK << 9); end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_async_reset();
    logic [15:0] bits; int len; int gl; int bad;
    pulse(8'h5A, 1'b1, 1'b0);
    repeat (35) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checks++; if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++; $display("FAIL async_rst: got tx=%b busy=%b expected tx=1 busy=0", bus.TX_OUT, bus.Busy);
    end
    @(negedge CLK);
    RST = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL async_post_idle: got %0d non-idle cycles expected 0", bad); end
    pulse(8'hA5, 1'b1, 1'b0);
    capture(bits, len, gl);
    checks++; if (bits !== (16'h014A | (STOP_MASK << 10)) || len !== P * (10 + NSTOP)) begin
      errors++; $display("FAIL async_new_frame: got bits=%h len=%0d expected bits=%h len=%0d",
                         bits, len, 16'h014A | (STOP_MASK << 10), P * (10 + NSTOP));
    end
  endtask

  task automatic test_prescale1();
    logic [15:0] bits; int len;
    fbus.P_DATA = 8'hA5; fbus.PAR_EN = 1'b1; fbus.PAR_TYP = 1'b0; fbus.Data_Valid = 1'b1;
    @(negedge CLK);
    fbus.Data_Valid = 1'b0;
    bits = '0; len = 0;
    while (fbus.Busy === 1'b1 && len < 40) begin
      if (len < 16) bits[len] = fbus.TX_OUT;
      len++;
      @(negedge CLK);
    end
    checks++; if (len !== 10 + NSTOP) begin errors++; $display("FAIL p1_len: got %0d expected %0d", len, 10 + NSTOP); end
    checks++; if (bits !== (16'h014A | (STOP_MASK << 10))) begin
      errors++; $display("FAIL p1_bits: got %h expected %h", bits, 16'h014A | (STOP_MASK << 10));
    end
    checks++; if (fbus.TX_OUT !== 1'b1) begin errors++; $display("FAIL p1_idle_tx: got %b expected 1", fbus.TX_OUT); end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_parity_even();
    test_parity_odd();
    test_no_parity();
    test_interference();
    test_back_to_back();
    test_async_reset();
    test_prescale1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
